// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with optional first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, exact fill level, sticky error flags and flush.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit FWFT = 1'b0,
    parameter int ALMOST_FULL_THRESH = (1 << ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  w_full,
    output logic                  w_almost_full,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_out,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wp, rp, rp_n, level_n;
    logic [DATA_WIDTH-1:0] head;
    logic w_acc, r_acc, load;
    always_comb begin
        w_acc = w_en & ~w_full & ~flush;
        r_acc = r_en & ~r_empty & ~flush;
        rp_n = rp + (ADDR_WIDTH+1)'(r_acc);
        level_n = flush ? '0 : level + (ADDR_WIDTH+1)'(w_acc) - (ADDR_WIDTH+1)'(r_acc);
        // In FWFT mode the next head may be the word being written this very edge.
        head = FWFT ? ((rp_n == wp) ? w_in : mem[rp_n[ADDR_WIDTH-1:0]]) : mem[rp[ADDR_WIDTH-1:0]];
        load = FWFT ? (level_n != '0) && (r_empty || r_acc) : r_acc;
    end
    always_ff @(posedge clk)
        if (w_acc)
            mem[wp[ADDR_WIDTH-1:0]] <= w_in;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
            r_out <= '0;
            w_full <= 1'b0;
            w_almost_full <= 1'b0;
            r_empty <= 1'b1;
            r_almost_empty <= 1'b1;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp <= flush ? '0 : wp + (ADDR_WIDTH+1)'(w_acc);
            rp <= flush ? '0 : rp_n;
            level <= level_n;
            r_out <= flush ? '0 : load ? head : r_out;
            w_full <= level_n == FULL_LVL;
            w_almost_full <= level_n >= AF_LVL;
            r_empty <= level_n == '0;
            r_almost_empty <= level_n <= AE_LVL;
            overflow <= ~flush & (overflow | (w_en & w_full));
            underflow <= ~flush & (underflow | (r_en & r_empty));
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of a standard-read and a FWFT instance driven by identical stimulus.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
    logic [15:0] w_in = '0;
    logic [15:0] r_out0, r_out1;
    logic w_full0, w_af0, r_empty0, r_ae0, ovf0, unf0;
    logic w_full1, w_af1, r_empty1, r_ae1, ovf1, unf1;
    logic [4:0] level0, level1;
    int n_chk = 0;
    int n_fail = 0;

    sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1'b0), .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_in(w_in), .w_full(w_full0),
        .w_almost_full(w_af0), .r_en(r_en), .r_out(r_out0), .r_empty(r_empty0),
        .r_almost_empty(r_ae0), .level(level0), .overflow(ovf0), .underflow(unf0));
    sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1'b1), .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_in(w_in), .w_full(w_full1),
        .w_almost_full(w_af1), .r_en(r_en), .r_out(r_out1), .r_empty(r_empty1),
        .r_almost_empty(r_ae1), .level(level1), .overflow(ovf1), .underflow(unf1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " r_out0"}, 32'(r_out0), 0);
        chk({tag, " r_out1"}, 32'(r_out1), 0);
        chk({tag, " r_empty"}, 32'(r_empty0), 1);
        chk({tag, " w_full"}, 32'(w_full0), 0);
        chk({tag, " w_almost_full"}, 32'(w_af0), 0);
        chk({tag, " r_almost_empty"}, 32'(r_ae0), 1);
        chk({tag, " level"}, 32'(level0), 0);
        chk({tag, " overflow"}, 32'(ovf0), 0);
        chk({tag, " underflow"}, 32'(unf0), 0);
        chk({tag, " level1"}, 32'(level1), 0);
        chk({tag, " r_empty1"}, 32'(r_empty1), 1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #2 chk_reset("reset");
        @(negedge clk) rst = 1'b0;

        // Test 1: fill, overflow, drain in standard mode
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; w_in = 16'(i);
            tick();
            chk("t1 fill level", 32'(level0), i);
            chk("t1 fill almost_full", 32'(w_af0), (i >= 14) ? 1 : 0);
            chk("t1 fill full", 32'(w_full0), (i == 16) ? 1 : 0);
            chk("t1 fill almost_empty", 32'(r_ae0), (i <= 2) ? 1 : 0);
        end
        w_in = 16'hDEAD;
        tick();
        chk("t1 overflow", 32'(ovf0), 1);
        chk("t1 level after drop", 32'(level0), 16);
        w_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            r_en = 1'b1;
            tick();
            chk("t1 drain data", 32'(r_out0), i);
            chk("t1 drain level", 32'(level0), 16 - i);
            chk("t1 drain empty", 32'(r_empty0), (i == 16) ? 1 : 0);
        end
        r_en = 1'b0;

        // Test 2: wrap-around at constant level 3
        for (int i = 0; i < 3; i++) begin
            w_en = 1'b1; w_in = 16'(16'h100 + i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            w_en = 1'b1; r_en = 1'b1; w_in = 16'(16'h103 + k);
            tick();
            chk("t2 data std", 32'(r_out0), 32'h100 + k);
            chk("t2 data fwft", 32'(r_out1), 32'h101 + k);
            chk("t2 level", 32'(level0), 3);
            chk("t2 full", 32'(w_full0), 0);
            chk("t2 empty", 32'(r_empty0), 0);
        end
        w_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t2 drain std", 32'(r_out0), 32'h128 + j);
        end
        r_en = 1'b0;
        chk("t2 empty after drain", 32'(r_empty0), 1);
        chk("t2 fwft holds last", 32'(r_out1), 32'h12A);

        // Test 3: FWFT fall-through and pop
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3 flush overflow", 32'(ovf0), 0);
        chk("t3 flush r_out1", 32'(r_out1), 0);
        w_en = 1'b1; w_in = 16'hABCD;
        tick();
        w_en = 1'b0;
        chk("t3 fwft r_empty", 32'(r_empty1), 0);
        chk("t3 fwft head", 32'(r_out1), 32'hABCD);
        w_en = 1'b1; w_in = 16'h1234;
        tick();
        w_en = 1'b0;
        chk("t3 fwft head kept", 32'(r_out1), 32'hABCD);
        r_en = 1'b1;
        tick();
        chk("t3 fwft pop", 32'(r_out1), 32'h1234);
        chk("t3 std read", 32'(r_out0), 32'hABCD);
        chk("t3 level1", 32'(level1), 1);
        tick();
        r_en = 1'b0;
        chk("t3 fwft empty", 32'(r_empty1), 1);
        chk("t3 fwft level", 32'(level1), 0);
        chk("t3 fwft hold", 32'(r_out1), 32'h1234);
        chk("t3 std read2", 32'(r_out0), 32'h1234);

        // Test 4: full with simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; w_in = 16'(16'h200 + i);
            tick();
        end
        chk("t4 full", 32'(w_full0), 1);
        chk("t4 overflow clear", 32'(ovf0), 0);
        w_in = 16'h5555; r_en = 1'b1;
        tick();
        w_en = 1'b0;
        chk("t4 level", 32'(level0), 15);
        chk("t4 overflow", 32'(ovf0), 1);
        chk("t4 std data", 32'(r_out0), 32'h200);
        chk("t4 fwft data", 32'(r_out1), 32'h201);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t4 drain std", 32'(r_out0), 32'h200 + i);
        end
        r_en = 1'b0;
        chk("t4 drained", 32'(level0), 0);
        chk("t4 fwft hold", 32'(r_out1), 32'h20F);

        // Test 5: empty with simultaneous read and write
        w_en = 1'b1; r_en = 1'b1; w_in = 16'h7777;
        tick();
        w_en = 1'b0;
        chk("t5 underflow", 32'(unf0), 1);
        chk("t5 level", 32'(level0), 1);
        chk("t5 std no read", 32'(r_out0), 32'h20F);
        chk("t5 fwft head", 32'(r_out1), 32'h7777);
        tick();
        r_en = 1'b0;
        chk("t5 std read", 32'(r_out0), 32'h7777);
        chk("t5 level after", 32'(level0), 0);

        // Test 6: flush beats write, then asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) begin
            w_en = 1'b1; w_in = 16'(16'h300 + i);
            tick();
        end
        chk("t6 level 10", 32'(level0), 10);
        flush = 1'b1; w_in = 16'h9999;
        tick();
        flush = 1'b0; w_en = 1'b0;
        chk("t6 flush level", 32'(level0), 0);
        chk("t6 flush empty", 32'(r_empty0), 1);
        chk("t6 flush ovf", 32'(ovf0), 0);
        chk("t6 flush unf", 32'(unf0), 0);
        chk("t6 flush r_out0", 32'(r_out0), 0);
        tick();
        chk("t6 write ignored", 32'(level0), 0);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("t6 underflow", 32'(unf0), 1);
        for (int i = 0; i < 3; i++) begin
            w_en = 1'b1; w_in = 16'(16'h400 + i);
            tick();
        end
        r_en = 1'b1; w_in = 16'h403;
        tick();
        chk("t6 burst r_out0", 32'(r_out0), 32'h400);
        chk("t6 burst level", 32'(level0), 3);
        #1 rst = 1'b1;
        #1 chk_reset("t6 async reset");
        w_en = 1'b0; r_en = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        chk("t6 post reset level", 32'(level0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
